// File: rtl/ram_arb_pkg.sv
// Shared types for the RAM access arbiter: FSM states, port owner and read tag.
// No logic of its own.
// Owner encoding is also used to tag in-flight reads.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        GRANT_CPU  = 2'd1,
        GRANT_HOST = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_CPU  = 1'b0,
        OWN_HOST = 1'b1
    } owner_e;

    // One entry per in-flight read: whether a read was issued and who asked.
    typedef struct packed {
        logic   vld;
        owner_e own;
    } rd_tag_t;

endpackage

// File: rtl/rd_tag_pipe.sv
// Delays the {valid, owner} tag of an issued read to line up with RAM data.
// Latency: RD_LAT cycles (RD_LAT is expected in 1..3).
// No backpressure: one tag enters every cycle and cannot be stalled.
module rd_tag_pipe
    import ram_arb_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic    i_main_clock,
    input  logic    i_reset,
    input  rd_tag_t i_tag,
    output rd_tag_t o_tag
);

    rd_tag_t r_stage [RD_LAT];

    // Shift the tag one stage per cycle; reset drops every in-flight read.
    always_ff @(posedge i_main_clock) begin
        if (i_reset) begin
            for (int i = 0; i < RD_LAT; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_tag;
            for (int i = 1; i < RD_LAT; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_tag = r_stage[RD_LAT-1];

endmodule

// File: rtl/ram_access_arbiter.sv
// Round-robin arbiter sharing one RAM port between the CPU and the host loader.
// Latency: grant 1 cycle after request (2 under contention); read data RD_LAT+1 after grant.
// Backpressure: requesters hold *_req until *_gnt; CPU_STALL gates the CPU clock enable.
module ram_access_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic              i_main_clock,
    input  logic              i_reset,
    input  logic              i_cpu_req,
    input  logic              i_cpu_write_en,
    input  logic [ADDR_W-1:0] i_cpu_address,
    input  logic [DATA_W-1:0] i_cpu_data,
    input  logic              i_host_req,
    input  logic              i_host_write_en,
    input  logic [ADDR_W-1:0] i_host_address,
    input  logic [DATA_W-1:0] i_host_data,
    output logic              o_cpu_gnt,
    output logic              o_host_gnt,
    output logic              o_cpu_stall,
    output logic [ADDR_W-1:0] o_ram_address,
    output logic [DATA_W-1:0] o_ram_data_in,
    output logic              o_ram_write_en,
    input  logic [DATA_W-1:0] i_data_from_ram,
    output logic              o_cpu_rdata_valid,
    output logic              o_host_rdata_valid,
    output logic [DATA_W-1:0] o_rdata
);

    arb_state_e        r_state;
    arb_state_e        w_state_nxt;
    owner_e            r_rr_last;
    owner_e            w_rr_nxt;
    logic              w_cpu_gnt;
    logic              w_host_gnt;
    rd_tag_t           w_tag_in;
    rd_tag_t           w_tag_out;
    logic              r_cpu_rvld;
    logic              r_host_rvld;
    logic [DATA_W-1:0] r_rdata;

    // State and round-robin pointer; the pointer remembers who was served last.
    always_ff @(posedge i_main_clock) begin
        if (i_reset) begin
            r_state   <= IDLE;
            r_rr_last <= OWN_HOST;
        end else begin
            r_state   <= w_state_nxt;
            r_rr_last <= w_rr_nxt;
        end
    end

    // Next state and grants. A grant needs its request still present, so a
    // request dropped before service is ignored; if the state owner has
    // dropped out, a waiting other side uses the slot instead of idling it.
    always_comb begin
        w_state_nxt = r_state;
        w_cpu_gnt   = 1'b0;
        w_host_gnt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_cpu_req && i_host_req) begin
                    w_state_nxt = (r_rr_last == OWN_HOST) ? GRANT_CPU : GRANT_HOST;
                end else if (i_cpu_req) begin
                    w_state_nxt = GRANT_CPU;
                end else if (i_host_req) begin
                    w_state_nxt = GRANT_HOST;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            GRANT_CPU: begin
                w_cpu_gnt  = i_cpu_req;
                w_host_gnt = ~i_cpu_req & i_host_req;
                if (i_host_req) begin
                    w_state_nxt = GRANT_HOST;
                end else if (i_cpu_req) begin
                    w_state_nxt = GRANT_CPU;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            GRANT_HOST: begin
                w_host_gnt = i_host_req;
                w_cpu_gnt  = ~i_host_req & i_cpu_req;
                if (i_cpu_req) begin
                    w_state_nxt = GRANT_CPU;
                end else if (i_host_req) begin
                    w_state_nxt = GRANT_HOST;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        if (i_reset) begin
            w_cpu_gnt  = 1'b0;
            w_host_gnt = 1'b0;
        end
        if (w_cpu_gnt) begin
            w_rr_nxt = OWN_CPU;
        end else if (w_host_gnt) begin
            w_rr_nxt = OWN_HOST;
        end else begin
            w_rr_nxt = r_rr_last;
        end
    end

    assign o_cpu_gnt      = w_cpu_gnt;
    assign o_host_gnt     = w_host_gnt;
    assign o_cpu_stall    = i_cpu_req & ~w_cpu_gnt;
    assign o_ram_address  = w_host_gnt ? i_host_address : i_cpu_address;
    assign o_ram_data_in  = w_host_gnt ? i_host_data    : i_cpu_data;
    assign o_ram_write_en = (w_cpu_gnt & i_cpu_write_en) | (w_host_gnt & i_host_write_en);

    // Only reads are tagged, so writes never produce a return pulse.
    assign w_tag_in.vld = (w_cpu_gnt & ~i_cpu_write_en) | (w_host_gnt & ~i_host_write_en);
    assign w_tag_in.own = w_host_gnt ? OWN_HOST : OWN_CPU;

    rd_tag_pipe #(
        .RD_LAT (RD_LAT)
    ) u_rd_tag_pipe (
        .i_main_clock (i_main_clock),
        .i_reset      (i_reset),
        .i_tag        (w_tag_in),
        .o_tag        (w_tag_out)
    );

    // Capture returned read data and steer the valid pulse to its owner.
    always_ff @(posedge i_main_clock) begin
        if (i_reset) begin
            r_cpu_rvld  <= 1'b0;
            r_host_rvld <= 1'b0;
            r_rdata     <= '0;
        end else begin
            r_cpu_rvld  <= w_tag_out.vld & (w_tag_out.own == OWN_CPU);
            r_host_rvld <= w_tag_out.vld & (w_tag_out.own == OWN_HOST);
            if (w_tag_out.vld) begin
                r_rdata <= i_data_from_ram;
            end
        end
    end

    assign o_cpu_rdata_valid  = r_cpu_rvld;
    assign o_host_rdata_valid = r_host_rvld;
    assign o_rdata            = r_rdata;

endmodule
